// File: rtl/ccff_pkg.sv
// Shared types and constants for the ccff chain loader.
// The VERIFY state only exists when CCFF_READBACK_EN is defined.
package ccff_pkg;

`ifdef CCFF_READBACK_EN
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StVerify = 2'd2,
    StDone   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd3
  } state_e;
`endif

  // CRC-16-CCITT, MSB-first serial form
  localparam logic [15:0] CrcPoly = 16'h1021;
  localparam logic [15:0] CrcInit = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16.sv
// One serial CRC-16 step: folds a single input bit into the running CRC.
module ccff_crc16
  import ccff_pkg::*;
(
  input  logic [15:0] crc_cur,
  input  logic        din,
  output logic [15:0] crc_nxt
);

  logic fb;

  // Shift left and apply the polynomial when the feedback bit is set
  always_comb begin
    fb      = crc_cur[15] ^ din;
    crc_nxt = {crc_cur[14:0], 1'b0} ^ (fb ? CrcPoly : 16'h0000);
  end

endmodule

// File: rtl/ccff_loader.sv
// Streams a bitstream into a ccff configuration chain, MSB of each word first.
// Optional readback (macro CCFF_READBACK_EN): recirculates the chain once and
// compares CRCs of the written and read-back streams, flagging err on mismatch.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] ChainLen = CntW'(CHAIN_LEN);
  localparam logic [CntW-1:0] LastBit  = CntW'(CHAIN_LEN - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sreg_q;
  logic [WCntW-1:0]  wcnt_q;     // bits still held in sreg_q
  logic [CntW-1:0]   bit_cnt_q;  // shifts done in the current phase
  logic              err_q;

  logic accept, load_shift, last_load;

  assign accept     = cfg_valid & cfg_ready;
  assign load_shift = (state_q == StLoad) && (wcnt_q != '0) && (bit_cnt_q < ChainLen);
  assign last_load  = load_shift && (bit_cnt_q == LastBit);

`ifdef CCFF_READBACK_EN
  logic        ver_shift, last_ver;
  logic [15:0] crc_a_q, crc_b_q, crc_a_nxt, crc_b_nxt;

  assign ver_shift = (state_q == StVerify);
  assign last_ver  = ver_shift && (bit_cnt_q == LastBit);

  ccff_crc16 u_crc_wr (
    .crc_cur (crc_a_q),
    .din     (ccff_head),
    .crc_nxt (crc_a_nxt)
  );

  ccff_crc16 u_crc_rd (
    .crc_cur (crc_b_q),
    .din     (ccff_tail),
    .crc_nxt (crc_b_nxt)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  // State register
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
`ifdef CCFF_READBACK_EN
      StLoad:   if (last_load) state_d = StVerify;
      StVerify: if (last_ver)  state_d = StDone;
`else
      StLoad: if (last_load) state_d = StDone;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from current state and datapath registers
  always_comb begin
    cfg_ready     = (state_q == StLoad) && (wcnt_q == '0) && (bit_cnt_q < ChainLen);
    ccff_shift_en = load_shift;
    ccff_head     = (state_q == StLoad) ? sreg_q[DATA_W-1] : 1'b0;
`ifdef CCFF_READBACK_EN
    if (ver_shift) begin
      ccff_shift_en = 1'b1;
      ccff_head     = ccff_tail;
    end
`endif
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    err  = err_q;
  end

  // Word shift register, counters, CRCs and sticky error flag
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sreg_q    <= '0;
      wcnt_q    <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
`ifdef CCFF_READBACK_EN
      crc_a_q   <= CrcInit;
      crc_b_q   <= CrcInit;
`endif
    end else if ((state_q == StIdle) && start) begin
      wcnt_q    <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
`ifdef CCFF_READBACK_EN
      crc_a_q   <= CrcInit;
      crc_b_q   <= CrcInit;
`endif
    end else if (accept) begin
      sreg_q <= cfg_data;
      wcnt_q <= WCntW'(DATA_W);
    end else if (load_shift) begin
      sreg_q <= sreg_q << 1;
      // Leftover LSBs of the final word are dropped here
      wcnt_q <= last_load ? '0 : wcnt_q - WCntW'(1);
`ifdef CCFF_READBACK_EN
      bit_cnt_q <= last_load ? '0 : bit_cnt_q + CntW'(1);
      crc_a_q   <= crc_a_nxt;
`else
      bit_cnt_q <= bit_cnt_q + CntW'(1);
`endif
    end
`ifdef CCFF_READBACK_EN
    else if (ver_shift) begin
      bit_cnt_q <= bit_cnt_q + CntW'(1);
      crc_b_q   <= crc_b_nxt;
      if (last_ver && (crc_a_q != crc_b_nxt)) err_q <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader with a behavioural chain model and a
// scoreboard of expected head bits. Readback cases build with CCFF_READBACK_EN.
module tb_ccff_loader;

  localparam int unsigned CHAIN_LEN = 20;
  localparam int unsigned DATA_W    = 8;
  localparam logic [CHAIN_LEN-1:0] Pattern = 20'hA53CF;

  logic              prog_clk = 1'b0;
  logic              pReset_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic              busy, done, err;

  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 stuck = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit exp_q[$];
  int load_shifts = 0;
  int ver_shifts  = 0;
  int last_shift_cyc = 0;
  int pushed = 0;
  int done_cyc = 0;

  ccff_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .DATA_W    (DATA_W)
  ) dut (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  // Chain model; optional stuck-at-1 on bit 5
  always @(posedge prog_clk) begin
    if (ccff_shift_en)
      chain <= {chain[CHAIN_LEN-2:0], ccff_head} | (stuck ? 20'h00020 : 20'h0);
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Scoreboard: pop expected head bit for each load shift
  always @(negedge prog_clk) begin
    if (pReset_n && ccff_shift_en) begin
      if (load_shifts < CHAIN_LEN) begin
        if (exp_q.size() == 0) check("head_unexpected", 32'd1, 32'd0);
        else check("head", {31'd0, ccff_head}, {31'd0, exp_q.pop_front()});
        load_shifts++;
        last_shift_cyc = cyc;
      end else begin
        ver_shifts++;
      end
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    load_shifts = 0;
    ver_shifts  = 0;
    pushed      = 0;
  endtask

  task automatic pulse_start(input bit fresh);
    if (fresh) clear_sb();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (!cfg_ready && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 100) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (pushed < CHAIN_LEN) begin
          exp_q.push_back(w[i]);
          pushed++;
        end
      end
      @(negedge prog_clk);
    end
    cfg_valid = 1'b0;
  endtask

  // Wait for the shift register to drain, then hold valid low and expect no shifts
  task automatic gap_check(input int n);
    int k;
    k = 0;
    while (!cfg_ready && k < 100) begin
      @(negedge prog_clk);
      k++;
    end
    for (int i = 0; i < n; i++) begin
      check("gap_shift_en", {31'd0, ccff_shift_en}, 32'd0);
      @(negedge prog_clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 300) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    done_cyc = cyc;
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_checks(input string tag);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
`ifndef CCFF_READBACK_EN
    check({tag, "_done_latency"}, done_cyc - last_shift_cyc, 32'd1);
`endif
    check({tag, "_shifts"}, load_shifts, CHAIN_LEN);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    @(negedge prog_clk);
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_chain"}, {12'd0, chain}, {12'd0, Pattern});
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_outputs", {26'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, err}, 32'd0);
    repeat (2) @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, cfg_ready}, 32'd0);

    // Back-to-back words
    pulse_start(1'b1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hF0);
    wait_done("b2b");
    finish_checks("b2b");

    // 5-cycle valid gaps between words
    pulse_start(1'b1);
    send_word(8'hA5);
    gap_check(5);
    send_word(8'h3C);
    gap_check(5);
    send_word(8'hF0);
    wait_done("gap");
    finish_checks("gap");

    // Start during LOAD is ignored
    pulse_start(1'b1);
    send_word(8'hA5);
    pulse_start(1'b0);
    send_word(8'h3C);
    pulse_start(1'b0);
    send_word(8'hF0);
    wait_done("midstart");
    finish_checks("midstart");

    // Reset mid-load after bit 7, then full reload
    pulse_start(1'b1);
    send_word(8'hA5);
    for (int i = 0; i < 50 && load_shifts < 7; i++) begin
      @(negedge prog_clk);
      #1;
    end
    check("rst_point", load_shifts, 32'd7);
    pReset_n = 1'b0;
    #1;
    check("midrst_outputs", {26'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, err},
          32'd0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    clear_sb();
    @(negedge prog_clk);
    pulse_start(1'b1);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hF0);
    wait_done("reload");
    finish_checks("reload");

`ifdef CCFF_READBACK_EN
    // Readback with a healthy chain
    pulse_start(1'b1);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hF0);
    wait_done("rb");
    check("rb_ver_shifts", ver_shifts, CHAIN_LEN);
    finish_checks("rb");

    // Stuck chain bit must flag err together with done
    stuck = 1'b1;
    pulse_start(1'b1);
    send_word(8'h00);
    send_word(8'h00);
    send_word(8'h00);
    wait_done("stuck");
    check("stuck_err", {31'd0, err}, 32'd1);
    @(negedge prog_clk);
    check("stuck_err_sticky", {31'd0, err}, 32'd1);
    stuck = 1'b0;
    pulse_start(1'b1);
    check("err_cleared", {31'd0, err}, 32'd0);
    send_word(8'h00);
    send_word(8'h00);
    send_word(8'h00);
    wait_done("clean");
    check("clean_err", {31'd0, err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
